// File: rtl/rtlola_event_queue.sv
// Input-event FIFO between the monitor input interface and the evaluation pipeline.
// Optional macro RTLOLA_EVENT_QUEUE_DROP_OLDEST_EN: a push into a full queue overwrites the oldest entry.
module rtlola_event_queue #(
    parameter int NUM_INPUTS = 2,
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 8,
    parameter int TS_W       = 32,
    parameter int TAG_W      = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [NUM_INPUTS*DATA_W-1:0]   input_data,
    input  logic [NUM_INPUTS-1:0]          new_input,
    input  logic                           pop,
    output logic [NUM_INPUTS*DATA_W-1:0]   head_data,
    output logic [NUM_INPUTS-1:0]          head_mask,
    output logic [TS_W-1:0]                head_ts,
    output logic [TAG_W-1:0]               llc_tag,
    output logic                           q_push,
    output logic                           q_push_valid,
    output logic                           q_pop,
    output logic                           q_pop_valid,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_INPUTS*DATA_W-1:0] mem_data [DEPTH];
    logic [NUM_INPUTS-1:0]        mem_mask [DEPTH];
    logic [TS_W-1:0]              mem_ts   [DEPTH];
    logic [TAG_W-1:0]             mem_tag  [DEPTH];

    logic [PTR_W-1:0]             wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]             count_nxt;
    logic [TS_W-1:0]              ts_ctr;
    logic [TAG_W-1:0]             tag_ctr;
    logic [NUM_INPUTS*DATA_W-1:0] in_vals;
    logic                         push_req, push_ok, pop_ok, drop_old, rd_adv, bypass;

    // Channels without a fresh strobe are stored as zero so stale bus values never leak.
    always_comb begin
        in_vals = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (new_input[i]) in_vals[i*DATA_W +: DATA_W] = input_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        push_req = en & (|new_input);
        pop_ok   = en & pop & ~empty;
`ifdef RTLOLA_EVENT_QUEUE_DROP_OLDEST_EN
        drop_old = push_req & full & ~pop_ok;
        push_ok  = push_req;
`else
        drop_old = 1'b0;
        push_ok  = push_req & (~full | pop_ok);
`endif
        rd_adv     = pop_ok | drop_old;
        rd_ptr_nxt = rd_adv ? rd_ptr + PTR_W'(1) : rd_ptr;
        case ({push_ok & ~drop_old, pop_ok})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        // The new head may be the slot written this very cycle (empty queue).
        bypass = push_ok & (wr_ptr == rd_ptr_nxt);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= in_vals;
            mem_mask[wr_ptr] <= new_input;
            mem_ts[wr_ptr]   <= ts_ctr;
            mem_tag[wr_ptr]  <= tag_ctr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            ts_ctr       <= '0;
            tag_ctr      <= '0;
            overflow     <= 1'b0;
            empty        <= 1'b1;
            full         <= 1'b0;
            q_push       <= 1'b0;
            q_push_valid <= 1'b0;
            q_pop        <= 1'b0;
            q_pop_valid  <= 1'b0;
            head_data    <= '0;
            head_mask    <= '0;
            head_ts      <= '0;
            llc_tag      <= '0;
        end else begin
            q_push       <= push_req;
            q_push_valid <= push_ok;
            q_pop        <= en & pop;
            q_pop_valid  <= pop_ok;
            if (en) ts_ctr <= ts_ctr + TS_W'(1);
            if (push_ok) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                tag_ctr <= tag_ctr + TAG_W'(1);
            end
            if ((push_req & ~push_ok) | drop_old) overflow <= 1'b1;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            empty  <= (count_nxt == '0);
            full   <= (count_nxt == CNT_W'(DEPTH));
            if (count_nxt != '0) begin
                if (bypass) begin
                    head_data <= in_vals;
                    head_mask <= new_input;
                    head_ts   <= ts_ctr;
                    llc_tag   <= tag_ctr;
                end else begin
                    head_data <= mem_data[rd_ptr_nxt];
                    head_mask <= mem_mask[rd_ptr_nxt];
                    head_ts   <= mem_ts[rd_ptr_nxt];
                    llc_tag   <= mem_tag[rd_ptr_nxt];
                end
            end
        end
    end
endmodule

// File: tb/tb_rtlola_event_queue.sv
// Scoreboard bench for rtlola_event_queue: model queue of expected head events, checked on every pop.
module tb_rtlola_event_queue;
    localparam int DEPTH = 8;
    localparam int EW    = 2 + 128 + 32 + 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [127:0]  input_data = '0;
    logic [1:0]    new_input = '0;
    logic          pop = 1'b0;
    logic [127:0]  head_data;
    logic [1:0]    head_mask;
    logic [31:0]   head_ts;
    logic [63:0]   llc_tag;
    logic          q_push, q_push_valid, q_pop, q_pop_valid, empty, full, overflow;
    logic [3:0]    count;

    rtlola_event_queue dut (
        .clk(clk), .rst(rst), .en(en), .input_data(input_data), .new_input(new_input),
        .pop(pop), .head_data(head_data), .head_mask(head_mask), .head_ts(head_ts),
        .llc_tag(llc_tag), .q_push(q_push), .q_push_valid(q_push_valid), .q_pop(q_pop),
        .q_pop_valid(q_pop_valid), .empty(empty), .full(full), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    int            m_count = 0;
    logic [31:0]   m_ts = '0;
    logic [63:0]   m_tag = '0;
    logic          m_ovf = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, score pops before the edge, check strobes after it.
    task automatic step(input logic e, input logic [1:0] ni, input logic [63:0] d0,
                        input logic [63:0] d1, input logic p);
        logic push_req, pop_ok, push_ok, drop;
        logic [63:0] v0, v1;
        logic [EW-1:0] exp_e;
        en = e; new_input = ni; input_data = {d1, d0}; pop = p;
        push_req = e & (|ni);
        pop_ok   = e & p & (m_count != 0);
`ifdef RTLOLA_EVENT_QUEUE_DROP_OLDEST_EN
        drop    = push_req & (m_count == DEPTH) & ~pop_ok;
        push_ok = push_req;
`else
        drop    = 1'b0;
        push_ok = push_req & ((m_count != DEPTH) | pop_ok);
`endif
        if (pop_ok) begin
            exp_e = exp_q.pop_front();
            check("head_event", 256'({head_mask, head_data, head_ts, llc_tag}), 256'(exp_e));
        end
        if (drop) void'(exp_q.pop_front());
        if (push_ok) begin
            v0 = ni[0] ? d0 : 64'd0;
            v1 = ni[1] ? d1 : 64'd0;
            exp_q.push_back({ni, v1, v0, m_ts, m_tag});
            m_tag++;
        end
        if ((push_req & ~push_ok) | drop) m_ovf = 1'b1;
        m_count = m_count + ((push_ok & ~drop) ? 1 : 0) - (pop_ok ? 1 : 0);
        if (e) m_ts++;
        @(posedge clk);
        @(negedge clk);
        check("q_push",       256'(q_push),       256'(push_req));
        check("q_push_valid", 256'(q_push_valid), 256'(push_ok));
        check("q_pop",        256'(q_pop),        256'(e & p));
        check("q_pop_valid",  256'(q_pop_valid),  256'(pop_ok));
        check("count",        256'(count),        256'(m_count));
        check("empty",        256'(empty),        256'(m_count == 0));
        check("full",         256'(full),         256'(m_count == DEPTH));
        check("overflow",     256'(overflow),     256'(m_ovf));
    endtask

    task automatic push_ev(input logic [1:0] ni, input logic [63:0] d0, input logic [63:0] d1);
        step(1'b1, ni, d0, d1, 1'b0);
    endtask

    task automatic pop_ev();
        step(1'b1, 2'b00, 64'd0, 64'd0, 1'b1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count = 0; m_ts = '0; m_tag = '0; m_ovf = 1'b0;
    endtask

    initial begin
        logic [31:0] ts_hold;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_empty", 256'(empty), 256'(1));
        check("rst_head",  256'({head_mask, head_data, head_ts, llc_tag}), 256'(0));

        repeat (10) step(1'b1, 2'b00, 64'd0, 64'd0, 1'b0);

        // Full capture, then pop; explicit checks of the first head.
        push_ev(2'b11, 64'd1, 64'd2);
        check("head_ch0", 256'(head_data[63:0]), 256'(1));
        check("head_ch1", 256'(head_data[127:64]), 256'(2));
        check("head_ts",  256'(head_ts), 256'(10));
        check("head_tag", 256'(llc_tag), 256'(0));
        pop_ev();

        // Partial event: unstrobed channel stored as zero.
        push_ev(2'b10, 64'd7, 64'd9);
        check("part_ch0",  256'(head_data[63:0]), 256'(0));
        check("part_mask", 256'(head_mask), 256'(2'b10));
        pop_ev();

        // Restart counters, then overflow with nine pushes and drain.
        rst = 1'b1; #1; rst = 1'b0; model_reset();
        for (int i = 0; i < 9; i++) push_ev(2'b01, 64'(100 + i), 64'd0);
        for (int i = 0; i < 8; i++) pop_ev();

        // Fill, then simultaneous push+pop while full.
        for (int i = 0; i < 8; i++) push_ev(2'b11, 64'(i), 64'(~i));
        step(1'b1, 2'b01, 64'hAA, 64'd0, 1'b1);
        step(1'b1, 2'b10, 64'd0, 64'hBB, 1'b1);
        for (int i = 0; i < 8; i++) pop_ev();
        // Simultaneous push+pop while empty: pop ignored.
        step(1'b1, 2'b11, 64'h55, 64'h66, 1'b1);
        pop_ev();

        // Frozen enable with three events queued.
        for (int i = 0; i < 3; i++) push_ev(2'b01, 64'(i + 20), 64'd0);
        ts_hold = head_ts;
        for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 64'hDEAD, 64'd0, 1'b1);
        check("frozen_head_ts", 256'(head_ts), 256'(ts_hold));

        // Asynchronous reset mid-stream with count=3.
        #2 rst = 1'b1;
        #1 check("async_empty", 256'(empty), 256'(1));
        check("async_count", 256'(count), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        push_ev(2'b01, 64'h77, 64'd0);
        check("post_rst_tag", 256'(llc_tag), 256'(0));
        check("post_rst_ts",  256'(head_ts), 256'(0));
        pop_ev();

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
        for (int i = 0; i < DEPTH + 1; i++) pop_ev();
        check("final_queue_len", 256'(exp_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
